ship_placer: RTL and testbench

Initiator side of the ship-placement check. It generates a random, in-bounds placement for the five ships and streams it as three packed words on `data_out`/`update_ship` to the placement-check accelerator. It then pulses `start`, samples the accelerator's combinational `valid_in`, and retries with a new placement until the result is valid or the attempt limit is hit. It sits between the game-control CPU interface (`go`/`done`/`fail`) and the accelerator's ship-update port.

---
 rtl/battleship_pkg.sv | 64 ++++++
 rtl/ship_lfsr.sv | 28 ++
 rtl/ship_placer.sv | 148 ++++++++++++++
 tb/tb_ship_placer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battleship_pkg.sv
// Shared constants, word layout, state encoding and draw helpers for the ship placer.
package battleship_pkg;

  localparam int NUM_SHIPS = 5;
  localparam int BOARD_DIM = 10;

  // Element i is the length of ship type i.
  localparam logic [NUM_SHIPS-1:0][3:0] SHIP_LEN = {4'd2, 4'd3, 4'd3, 4'd4, 4'd5};

  localparam int SLOT_A_POS_LSB  = 25;
  localparam int SLOT_A_VERT_BIT = 24;
  localparam int SLOT_A_TYPE_LSB = 21;
  localparam int SLOT_B_POS_LSB  = 14;
  localparam int SLOT_B_VERT_BIT = 13;
  localparam int SLOT_B_TYPE_LSB = 10;

  localparam logic [2:0]  EMPTY_SLOT_TYPE = 3'd7;
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;

  typedef struct packed {
    logic [6:0] pos;
    logic       vert;
  } ship_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_SEND0,
    ST_SEND1,
    ST_SEND2,
    ST_CHECK
  } placer_state_t;

  function automatic logic [31:0] pack_word(input ship_t a, input logic [2:0] type_a,
                                            input ship_t b, input logic [2:0] type_b);
    logic [31:0] w;
    w = '0;
    w[SLOT_A_POS_LSB +: 7]  = a.pos;
    w[SLOT_A_VERT_BIT]      = a.vert;
    w[SLOT_A_TYPE_LSB +: 3] = type_a;
    w[SLOT_B_POS_LSB +: 7]  = b.pos;
    w[SLOT_B_VERT_BIT]      = b.vert;
    w[SLOT_B_TYPE_LSB +: 3] = type_b;
    return w;
  endfunction

  // A ship fits when its anchor is on the board and its far end does not pass the edge.
  function automatic logic draw_ok(input logic [3:0] row, input logic [3:0] col,
                                   input logic vert, input logic [3:0] len);
    logic [4:0] end_row;
    logic [4:0] end_col;
    end_row = {1'b0, row} + {1'b0, len};
    end_col = {1'b0, col} + {1'b0, len};
    return (row <= 4'(BOARD_DIM - 1)) && (col <= 4'(BOARD_DIM - 1)) &&
           (vert ? (end_row <= 5'(BOARD_DIM)) : (end_col <= 5'(BOARD_DIM)));
  endfunction

  function automatic logic [6:0] board_pos(input logic [3:0] row, input logic [3:0] col);
    logic [6:0] r;
    r = {3'b000, row};
    return (r << 3) + (r << 1) + {3'b000, col};
  endfunction

endpackage

// File: rtl/ship_lfsr.sv
// 16-bit Galois LFSR with asynchronous reset and a synchronous seed load.
module ship_lfsr
  import battleship_pkg::*;
#(
  parameter logic [15:0] RESET_VALUE = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [8:0]  draw
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_VALUE;
    end else if (load) begin
      state <= seed;
    end else begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign draw = state[8:0];

endmodule

// File: rtl/ship_placer.sv
// Random ship placement initiator: draws, streams three words, checks, retries.
// Optional `seed` port and seed load on request are enabled by SHIP_PLACER_SEED_EN.
module ship_placer
  import battleship_pkg::*;
#(
  parameter int          MAX_ATTEMPTS = 255,
  parameter logic [15:0] RESET_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic        valid_in,
`ifdef SHIP_PLACER_SEED_EN
  input  logic [15:0] seed,
`endif
  output logic [31:0] data_out,
  output logic        update_ship,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [7:0]  attempts
);

  localparam logic [7:0] ATTEMPT_LIMIT = 8'(MAX_ATTEMPTS);
  localparam logic [2:0] LAST_SHIP     = 3'(NUM_SHIPS - 1);

  placer_state_t state;
  ship_t         ships [NUM_SHIPS];
  logic [2:0]    ship_idx;
  logic [8:0]    draw;
  logic          lfsr_load;
  logic [15:0]   lfsr_seed;

`ifdef SHIP_PLACER_SEED_EN
  assign lfsr_load = (state == ST_IDLE) && go;
  assign lfsr_seed = (seed == 16'h0000) ? RESET_SEED : seed;
`else
  assign lfsr_load = 1'b0;
  assign lfsr_seed = RESET_SEED;
`endif

  ship_lfsr #(
    .RESET_VALUE(RESET_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .seed (lfsr_seed),
    .draw (draw)
  );

  logic [3:0] draw_row;
  logic [3:0] draw_col;
  logic       draw_vert;
  logic       draw_fits;
  logic [7:0] attempts_next;

  assign draw_row      = draw[3:0];
  assign draw_col      = draw[7:4];
  assign draw_vert     = draw[8];
  assign draw_fits     = draw_ok(draw_row, draw_col, draw_vert, SHIP_LEN[ship_idx]);
  assign attempts_next = (attempts == 8'hFF) ? attempts : attempts + 8'd1;

  // A rejected draw just waits for the next LFSR value; the ship index only moves on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ship_idx <= '0;
      attempts <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      for (int i = 0; i < NUM_SHIPS; i++) begin
        ships[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_GEN;
            attempts <= '0;
            ship_idx <= '0;
            busy     <= 1'b1;
          end
        end
        ST_GEN: begin
          if (draw_fits) begin
            ships[ship_idx] <= '{pos: board_pos(draw_row, draw_col), vert: draw_vert};
            if (ship_idx == LAST_SHIP) begin
              state <= ST_SEND0;
            end else begin
              ship_idx <= ship_idx + 3'd1;
            end
          end
        end
        ST_SEND0: state <= ST_SEND1;
        ST_SEND1: state <= ST_SEND2;
        ST_SEND2: state <= ST_CHECK;
        ST_CHECK: begin
          attempts <= attempts_next;
          if (valid_in) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (attempts_next == ATTEMPT_LIMIT) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state    <= ST_GEN;
            ship_idx <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Streamed words and the check strobe follow the state directly so reset clears them at once.
  always_comb begin
    data_out    = '0;
    update_ship = 1'b0;
    start       = 1'b0;
    case (state)
      ST_SEND0: begin
        update_ship = 1'b1;
        data_out    = pack_word(ships[0], 3'd0, ships[1], 3'd1);
      end
      ST_SEND1: begin
        update_ship = 1'b1;
        data_out    = pack_word(ships[2], 3'd2, ships[3], 3'd3);
      end
      ST_SEND2: begin
        update_ship = 1'b1;
        data_out    = pack_word(ships[4], 3'd4, '0, EMPTY_SLOT_TYPE);
      end
      ST_CHECK: start = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ship_placer.sv
// Self-checking bench for ship_placer: reference LFSR/draw predictor feeding a word scoreboard.
`timescale 1ns/1ps
module tb_ship_placer;

  localparam int          MAX_ATT = 3;
  localparam logic [15:0] SEED0   = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        valid_in;
  logic [31:0] data_out;
  logic        update_ship, start, busy, done, fail;
  logic [7:0]  attempts;
`ifdef SHIP_PLACER_SEED_EN
  logic [15:0] seed = 16'h1D2B;
`endif

  ship_placer #(
    .MAX_ATTEMPTS(MAX_ATT),
    .RESET_SEED  (SEED0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .valid_in   (valid_in),
`ifdef SHIP_PLACER_SEED_EN
    .seed       (seed),
`endif
    .data_out   (data_out),
    .update_ship(update_ship),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .attempts   (attempts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int failCount = 0;
  int rejectTarget = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int lenOf(input int t);
    case (t)
      0: return 5;
      1: return 4;
      2: return 3;
      3: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] mkWord(input int pa, input bit va, input int ta,
                                         input int pb, input bit vb, input int tb);
    return {7'(pa), va, 3'(ta), 7'(pb), vb, 3'(tb), 10'd0};
  endfunction

  // Walks the draw sequence from the first GEN-cycle LFSR value; returns the GEN cycle count.
  function automatic int predictShips(input logic [15:0] v0, output logic [31:0] w0,
                                      output logic [31:0] w1, output logic [31:0] w2);
    logic [15:0] v;
    int idx, cyc, row, col, len;
    bit vert;
    int pos [5];
    bit vt [5];
    v = v0; idx = 0; cyc = 0;
    for (int i = 0; i < 5; i++) begin pos[i] = 0; vt[i] = 0; end
    while (idx < 5 && cyc < 4000) begin
      row = int'(v[3:0]); col = int'(v[7:4]); vert = v[8]; len = lenOf(idx);
      if (row < 10 && col < 10 && (vert ? (row + len <= 10) : (col + len <= 10))) begin
        pos[idx] = row * 10 + col;
        vt[idx]  = vert;
        idx++;
      end
      cyc++;
      v = lfsrStep(v);
    end
    w0 = mkWord(pos[0], vt[0], 0, pos[1], vt[1], 1);
    w1 = mkWord(pos[2], vt[2], 2, pos[3], vt[3], 3);
    w2 = mkWord(pos[4], vt[4], 4, 0, 1'b0, 7);
    return cyc;
  endfunction

  function automatic bit slotOk(input logic [6:0] pos, input logic vert, input int len);
    int row, col;
    row = int'(pos) / 10;
    col = int'(pos) % 10;
    return (pos < 7'd100) && (vert ? (row + len <= 10) : (col + len <= 10));
  endfunction

  function automatic bit wordOk(input logic [31:0] w, input int k);
    bit ok;
    ok = (w[9:0] == 10'd0) && (int'(w[23:21]) == 2 * k) && slotOk(w[31:25], w[24], lenOf(2 * k));
    if (k < 2) ok = ok && (int'(w[12:10]) == 2 * k + 1) && slotOk(w[20:14], w[13], lenOf(2 * k + 1));
    else       ok = ok && (w[20:10] == {7'd0, 1'b0, 3'd7});
    return ok;
  endfunction

  // Reference model: current-cycle LFSR value plus a phase tracker.
  logic [15:0] m;
  int ph = 0;
  int genLeft = 0;
  int sendIdx = 0;
  int mAtt = 0;
  bit mDone = 0;
  bit mFail = 0;
  logic [31:0] sbq[$];
`ifdef SHIP_PLACER_SEED_EN
  bit mLoad = 0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= SEED0;
`ifdef SHIP_PLACER_SEED_EN
    else if (mLoad) m <= (seed == 16'h0000) ? SEED0 : seed;
`endif
    else m <= lfsrStep(m);
  end

  task automatic startGen(input logic [15:0] v);
    logic [31:0] a, b, c;
    genLeft = predictShips(v, a, b, c);
    sbq.push_back(a);
    sbq.push_back(b);
    sbq.push_back(c);
    ph = 1;
  endtask

  always @(negedge clk) begin
    logic [31:0] w;
    int na;
    if (!rst_n) begin
      ph = 0; mAtt = 0; mDone = 0; mFail = 0; genLeft = 0; sendIdx = 0;
      sbq.delete();
      valid_in = 1'b0;
`ifdef SHIP_PLACER_SEED_EN
      mLoad = 0;
`endif
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_fail", fail, 0);
      checkOutput("rst_attempts", attempts, 0);
      checkOutput("rst_update", update_ship, 0);
      checkOutput("rst_start", start, 0);
      checkOutput("rst_data", data_out, 0);
    end else begin
      valid_in = (mAtt >= rejectTarget);
      checkOutput("busy", busy, ph != 0);
      checkOutput("done", done, mDone);
      checkOutput("fail", fail, mFail);
      checkOutput("attempts", attempts, mAtt);
      checkOutput("start", start, ph == 3);
      checkOutput("update_ship", update_ship, ph == 2);
      if (ph == 2) begin
        checkOutput("sb_level", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          w = sbq.pop_front();
          checkOutput("data_out", data_out, w);
          checkOutput("word_shape", wordOk(data_out, sendIdx), 1);
        end
      end else begin
        checkOutput("data_zero", data_out, 0);
      end
      if (done) doneCount++;
      if (fail) failCount++;
      mDone = 0;
      mFail = 0;
`ifdef SHIP_PLACER_SEED_EN
      mLoad = 0;
`endif
      case (ph)
        0: if (go) begin
          mAtt = 0;
`ifdef SHIP_PLACER_SEED_EN
          mLoad = 1;
          startGen((seed == 16'h0000) ? SEED0 : seed);
`else
          startGen(lfsrStep(m));
`endif
        end
        1: begin
          genLeft--;
          if (genLeft <= 0) begin ph = 2; sendIdx = 0; end
        end
        2: begin
          sendIdx++;
          if (sendIdx == 3) ph = 3;
        end
        default: begin
          na = (mAtt == 255) ? 255 : mAtt + 1;
          mAtt = na;
          if (valid_in) begin mDone = 1; ph = 0; end
          else if (na == MAX_ATT) begin mFail = 1; ph = 0; end
          else startGen(lfsrStep(m));
        end
      endcase
    end
  end

  typedef struct {
    int rejects;
    bit noise;
    bit expFail;
    int expAtt;
  } vec_t;

  task automatic waitSend0(output bit seen);
    seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (update_ship) seen = 1;
    end
    if (!seen) checkOutput("send0_timeout", 0, 1);
  endtask

  task automatic waitOutcome(input int d0, input int f0, output bit seen);
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk); #1;
      if (doneCount > d0 || failCount > f0) seen = 1;
    end
    if (!seen) checkOutput("outcome_timeout", 0, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int d0, f0;
    bit seen;
    d0 = doneCount;
    f0 = failCount;
    @(posedge clk); #1;
    rejectTarget = v.rejects;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    if (v.noise) begin
      waitSend0(seen);
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
    end
    waitOutcome(d0, f0, seen);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("vec_done_count", doneCount - d0, v.expFail ? 0 : 1);
    checkOutput("vec_fail_count", failCount - f0, v.expFail ? 1 : 0);
    checkOutput("vec_attempts", attempts, v.expAtt);
    checkOutput("vec_idle", busy, 0);
  endtask

  initial begin
    vec_t vecs [7];
    vec_t r;
    int d0, f0;
    bit seen;
    vecs[0] = '{0, 1'b0, 1'b0, 1};
    vecs[1] = '{1, 1'b0, 1'b0, 2};
    vecs[2] = '{2, 1'b0, 1'b0, 3};
    vecs[3] = '{3, 1'b0, 1'b1, 3};
    vecs[4] = '{0, 1'b1, 1'b0, 1};
    vecs[5] = '{1, 1'b1, 1'b0, 2};
    vecs[6] = '{6, 1'b0, 1'b1, 3};

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    for (int i = 0; i < 40; i++) begin
      r.rejects = int'($urandom_range(0, 4));
      r.noise   = $urandom_range(0, 1) == 1;
      r.expFail = r.rejects >= MAX_ATT;
      r.expAtt  = (r.rejects >= MAX_ATT) ? MAX_ATT : r.rejects + 1;
      applyStimulus(r);
    end

    // go held high: a second request must start the cycle after done.
    d0 = doneCount;
    @(posedge clk); #1;
    rejectTarget = 0;
    go = 1'b1;
    waitOutcome(d0, failCount, seen);
    go = 1'b0;
    checkOutput("hold_restart_busy", busy, 1);
    waitOutcome(d0 + 1, failCount, seen);
    checkOutput("hold_done_total", doneCount - d0, 2);

    // Asynchronous reset in SEND1 clears outputs before the next edge.
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    waitSend0(seen);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_update", update_ship, 0);
    checkOutput("async_rst_data", data_out, 0);
    checkOutput("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
